rxpybitpacker: RTL and testbench
================================

# rxpybitpacker

Receive-side payload bit packer for the link controller. Takes the serial stream of decoded payload bits and packs it LSB-first into 32-bit words. Writes those words into the rx payload buffers through the rxlnctrl_addr/rxlnctrl_din/rxlnctrl_we port. It is the write-side mirror of the tx payload path, which reads buffer word pybitcount[12:5] and serialises bit pybitcount[4:0]. The ACL/SCO buffer selection (via lnctrl_cs) stays in the buffer controller; this block only produces the write stream.

## Interface
- No parameters; word width fixed at 32, address width at 8, bit-count width at 13.
- clk_6M  in  1  system clock, 6 MHz.
- rstz  in  1  reset: asynchronous, active-low.
- py_st_p  in  1  one-cycle pulse at payload start; (re)starts packing.
- dec_py_period  in  1  payload decode window; packing is only active while high.
- rxbit_valid  in  1  strobe: rxbit carries the next payload bit this cycle.
- rxbit  in  1  decoded (de-whitened, FEC-corrected) payload bit.
- pylen_valid_p  in  1  pulse: dec_pylenByte is valid; latch the length limit.
- dec_pylenByte  in  10  payload length in bytes, counting all stored bits.
- py_endp  in  1  one-cycle pulse at end of payload; flush the partial word.
- rxlnctrl_addr  out  8  buffer word address.
- rxlnctrl_din  out  32  buffer write data.
- rxlnctrl_we  out  1  one-cycle write strobe.
- rxpybitcount  out  13  number of bits stored so far in this payload.
- pack_done_p  out  1  pulse: payload fully written to the buffer.
- rxpy_overflow  out  1  sticky: bits were dropped because of the length limit or buffer size.

## Operation
- State machine states: IDLE, COLLECT, FLUSH, DONE.
- IDLE -> COLLECT on py_st_p while dec_py_period=1. On entry:
  - clear the bit counter, shift register and overflow flag;
  - set the length limit to 8192 bits (unlimited).
- COLLECT, on rxbit_valid:
  - if the bit is accepted (see rules below), write rxbit into word[cnt[4:0]] and increment cnt;
  - when cnt[4:0] rolls over from 31 to 0, issue a full-word write.
- Length limit: pylen_valid_p latches limit = dec_pylenByte×8, computed in 13 bits; dec_pylenByte=0 gives limit 0.
- A bit is dropped, and rxpy_overflow set, when cnt ≥ limit or cnt has saturated at 8191 with the last word already written.
- Bit-to-buffer mapping: bit index n goes to word n[12:5], position n[4:0].
- Word register handling: after every write the word register clears. In a partial word, unfilled upper bits read 0.
- COLLECT -> FLUSH on py_endp:
  - if cnt[4:0]≠0, FLUSH writes the partial word at address cnt[12:5];
  - if cnt[4:0]=0, FLUSH performs no write.
- FLUSH -> DONE, then DONE -> IDLE. pack_done_p is high in the DONE cycle.
- Abort: dec_py_period falling in COLLECT without py_endp → IDLE. No flush, no pack_done_p; rxpybitcount holds its value.
- py_st_p in any non-IDLE state restarts immediately: the partial word is discarded and no write occurs.
- rxbit_valid outside COLLECT is ignored.

## Timing
- Reset values:
  - state = IDLE;
  - rxlnctrl_addr = 0, rxlnctrl_din = 0, rxlnctrl_we = 0;
  - rxpybitcount = 0, pack_done_p = 0, rxpy_overflow = 0.
- Full-word write: rxlnctrl_we is high the cycle after the 32nd bit's rxbit_valid, with addr = word index and din = the completed word. All three outputs are registered.
- Flush write: rxlnctrl_we is high in the FLUSH cycle, one cycle after py_endp.
- pack_done_p comes one cycle after FLUSH, i.e. 2 cycles after py_endp.
- Bit and end in the same cycle (rxbit_valid with py_endp): the bit is stored first, then the flush.
  - If that bit completes a word, exactly one write occurs (the full-word write) and FLUSH does not write again.
- rxbit_valid with py_st_p in the same cycle: the bit becomes bit 0 of the new payload.
- pylen_valid_p with the cnt already ≥ new limit: later bits are dropped; already-written words are not retracted.
- Minimum spacing between rxbit_valid strobes is 1 cycle. Back-to-back strobes must sustain one write every 32 cycles with no loss.
- rstz assertion mid-payload clears everything asynchronously; no write strobe is emitted.

## Structure
- Shared baseband package holds:
  - the constants RXPY_WORD_W=32, RXPY_ADDR_W=8, RXPY_CNT_W=13;
  - the packer state encoding.
- Single module, no sub-modules. The shift/word register, counter, limit register and FSM are all local.
- Instantiated beside the rx buffer controller. Its outputs drive rxlnctrl_addr/rxlnctrl_din/rxlnctrl_we directly.

## Test plan
- 64 bits alternating 1,0 then py_endp:
  - writes at addr 0 and addr 1, each with din=32'h5555_5555;
  - no flush write;
  - pack_done_p 2 cycles after py_endp;
  - rxpybitcount=64.
- 40 bits of all 1s then py_endp:
  - addr 0 din=32'hFFFF_FFFF;
  - addr 1 din=32'h0000_00FF, written in the FLUSH cycle.
- pylen_valid_p with dec_pylenByte=2, then 24 bits of 1s:
  - flush writes addr 0 din=32'h0000_FFFF;
  - rxpy_overflow=1;
  - rxpybitcount=16.
- 32nd bit arrives together with py_endp: exactly one write (addr 0), then pack_done_p.
- dec_py_period drops after 10 bits: no write, no pack_done_p, state IDLE.
- py_st_p after 20 bits, then 32 bits of 1s: single write addr 0 din=32'hFFFF_FFFF; the stale partial word is never written.

Source files
------------

// File: rtl/rxpybitpacker_pkg.sv
// Shared baseband constants and the rx payload bit packer state encoding.
package rxpybitpacker_pkg;

    localparam int RXPY_WORD_W = 32;
    localparam int RXPY_ADDR_W = 8;
    localparam int RXPY_CNT_W  = 13;

    // One bit wider than the counter so that "unlimited" (8192 bits) is representable.
    localparam logic [RXPY_CNT_W:0] RXPY_LIM_MAX = 14'd8192;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } rxpy_state_e;

endpackage

// File: rtl/rxpybitpacker.sv
// Receive payload bit packer: packs serial payload bits LSB-first into 32-bit
// words and emits registered write strobes towards the rx payload buffers.
module rxpybitpacker
    import rxpybitpacker_pkg::*;
(
    input  logic                   clk_6M,
    input  logic                   rstz,
    input  logic                   py_st_p,
    input  logic                   dec_py_period,
    input  logic                   rxbit_valid,
    input  logic                   rxbit,
    input  logic                   pylen_valid_p,
    input  logic [9:0]             dec_pylenByte,
    input  logic                   py_endp,
    output logic [RXPY_ADDR_W-1:0] rxlnctrl_addr,
    output logic [RXPY_WORD_W-1:0] rxlnctrl_din,
    output logic                   rxlnctrl_we,
    output logic [RXPY_CNT_W-1:0]  rxpybitcount,
    output logic                   pack_done_p,
    output logic                   rxpy_overflow
);

    rxpy_state_e            state_q, state_d;
    logic [RXPY_CNT_W-1:0]  cnt_q,   cnt_d;
    logic [RXPY_WORD_W-1:0] word_q,  word_d;
    logic [RXPY_CNT_W:0]    lim_q,   lim_d;
    logic                   full_q,  full_d;
    logic                   ovf_q,   ovf_d;
    logic [RXPY_ADDR_W-1:0] addr_q,  addr_d;
    logic [RXPY_WORD_W-1:0] din_q,   din_d;
    logic                   we_q,    we_d;
    logic                   start;
    logic                   proc;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            lim_q   <= RXPY_LIM_MAX;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            lim_q   <= lim_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        lim_d   = lim_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        start   = py_st_p && dec_py_period;
        proc    = 1'b0;

        // A start pulse restarts from any state; a bit in the same cycle becomes bit 0.
        if (start) begin
            state_d = COLLECT;
            cnt_d   = '0;
            word_d  = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
            lim_d   = RXPY_LIM_MAX;
            proc    = 1'b1;
        end else if (state_q == COLLECT) begin
            proc = 1'b1;
        end

        if (proc && pylen_valid_p)
            lim_d = {1'b0, dec_pylenByte, 3'b000};

        if (proc && rxbit_valid) begin
            if (!full_d && ({1'b0, cnt_d} < lim_d)) begin
                word_d[cnt_d[4:0]] = rxbit;
                if (&cnt_d[4:0]) begin
                    we_d   = 1'b1;
                    addr_d = cnt_d[12:5];
                    din_d  = word_d;
                    word_d = '0;
                end
                // Bit 8191 fills the last buffer word; the counter cannot reach 8192.
                if (&cnt_d)
                    full_d = 1'b1;
                else
                    cnt_d = cnt_d + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (!start) begin
            case (state_q)
                IDLE: ;
                COLLECT: begin
                    if (py_endp) begin
                        state_d = FLUSH;
                        // Flush is decided on the post-bit count, so a word completed
                        // by a simultaneous bit is never written twice.
                        if ((cnt_d[4:0] != 5'd0) && !full_d) begin
                            we_d   = 1'b1;
                            addr_d = cnt_d[12:5];
                            din_d  = word_d;
                            word_d = '0;
                        end
                    end else if (!dec_py_period) begin
                        state_d = IDLE;
                    end
                end
                FLUSH:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign rxlnctrl_addr = addr_q;
    assign rxlnctrl_din  = din_q;
    assign rxlnctrl_we   = we_q;
    assign rxpybitcount  = cnt_q;
    assign pack_done_p   = (state_q == DONE);
    assign rxpy_overflow = ovf_q;

endmodule

// File: tb/tb_rxpybitpacker.sv
// Self-checking bench for rxpybitpacker: directed corner cases plus random
// payloads compared against a word-level packing model.
module tb_rxpybitpacker;

    logic        clk_6M = 1'b0;
    logic        rstz;
    logic        py_st_p, dec_py_period, rxbit_valid, rxbit, pylen_valid_p, py_endp;
    logic [9:0]  dec_pylenByte;
    logic [7:0]  rxlnctrl_addr;
    logic [31:0] rxlnctrl_din;
    logic        rxlnctrl_we;
    logic [12:0] rxpybitcount;
    logic        pack_done_p;
    logic        rxpy_overflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_n = 0;
    int done_cyc = -1;
    int endp_cyc = -1;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic        pl_bits[$];

    rxpybitpacker dut (
        .clk_6M        (clk_6M),
        .rstz          (rstz),
        .py_st_p       (py_st_p),
        .dec_py_period (dec_py_period),
        .rxbit_valid   (rxbit_valid),
        .rxbit         (rxbit),
        .pylen_valid_p (pylen_valid_p),
        .dec_pylenByte (dec_pylenByte),
        .py_endp       (py_endp),
        .rxlnctrl_addr (rxlnctrl_addr),
        .rxlnctrl_din  (rxlnctrl_din),
        .rxlnctrl_we   (rxlnctrl_we),
        .rxpybitcount  (rxpybitcount),
        .pack_done_p   (pack_done_p),
        .rxpy_overflow (rxpy_overflow)
    );

    always #5 clk_6M = ~clk_6M;
    always @(posedge clk_6M) cyc <= cyc + 1;

    always @(negedge clk_6M) begin
        if (rxlnctrl_we) begin
            wa_q.push_back(rxlnctrl_addr);
            wd_q.push_back(rxlnctrl_din);
            wc_q.push_back(cyc);
        end
        if (pack_done_p) begin
            done_n++;
            done_cyc = cyc;
        end
        if (py_endp) endp_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_6M); #1;
        end
    endtask

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        pl_bits.delete();
        done_n = 0; done_cyc = -1; endp_cyc = -1;
    endtask

    task automatic start_pl();
        dec_py_period = 1'b1; py_st_p = 1'b1;
        @(posedge clk_6M); #1;
        py_st_p = 1'b0;
    endtask

    task automatic bit_cyc(input logic b, input logic endp);
        rxbit_valid = 1'b1; rxbit = b; py_endp = endp;
        @(posedge clk_6M); #1;
        rxbit_valid = 1'b0; py_endp = 1'b0;
    endtask

    task automatic end_pl();
        py_endp = 1'b1;
        @(posedge clk_6M); #1;
        py_endp = 1'b0;
        idle(4);
    endtask

    // Expected writes: one per started 32-bit word of the stored bits, LSB-first, zero-filled.
    task automatic check_writes(input string tag, input int stored);
        int nw;
        logic [31:0] w;
        nw = (stored + 31) / 32;
        chk({tag, "_nwr"}, wa_q.size(), nw);
        for (int k = 0; k < nw && k < wa_q.size(); k++) begin
            w = '0;
            for (int j = 0; j < 32; j++)
                if (k * 32 + j < stored) w[j] = pl_bits[k * 32 + j];
            chk({tag, "_addr"}, wa_q[k], k);
            chk({tag, "_din"}, wd_q[k], w);
        end
    endtask

    initial begin
        int nb, lim, lb, stored;
        logic uselim, together, b, last;

        rstz = 1'b0; py_st_p = 1'b0; dec_py_period = 1'b0; rxbit_valid = 1'b0;
        rxbit = 1'b0; pylen_valid_p = 1'b0; dec_pylenByte = '0; py_endp = 1'b0;
        #1;
        chk("rst_addr", rxlnctrl_addr, 0);
        chk("rst_din",  rxlnctrl_din,  0);
        chk("rst_we",   rxlnctrl_we,   0);
        chk("rst_cnt",  rxpybitcount,  0);
        chk("rst_done", pack_done_p,   0);
        chk("rst_ovf",  rxpy_overflow, 0);
        #20 rstz = 1'b1;
        @(posedge clk_6M); #1;

        // 64 alternating bits: two full words, no flush
        clear_mon(); start_pl();
        for (int i = 0; i < 64; i++) begin
            b = ~i[0]; pl_bits.push_back(b); bit_cyc(b, 1'b0);
        end
        end_pl();
        check_writes("alt", 64);
        chk("alt_din0", wd_q[0], 32'h5555_5555);
        chk("alt_done_n", done_n, 1);
        chk("alt_done_lat", done_cyc - endp_cyc, 2);
        chk("alt_cnt", rxpybitcount, 64);

        // 40 ones: full word plus an 8-bit partial flushed in FLUSH
        clear_mon(); start_pl();
        for (int i = 0; i < 40; i++) begin
            pl_bits.push_back(1'b1); bit_cyc(1'b1, 1'b0);
        end
        end_pl();
        check_writes("ones40", 40);
        chk("ones40_din1", wd_q[1], 32'h0000_00FF);
        chk("ones40_flush_lat", wc_q[1] - endp_cyc, 1);
        chk("ones40_done_lat", done_cyc - endp_cyc, 2);

        // Length limit of 2 bytes with 24 bits offered
        clear_mon(); start_pl();
        pylen_valid_p = 1'b1; dec_pylenByte = 10'd2;
        @(posedge clk_6M); #1;
        pylen_valid_p = 1'b0;
        for (int i = 0; i < 24; i++) begin
            pl_bits.push_back(1'b1); bit_cyc(1'b1, 1'b0);
        end
        end_pl();
        check_writes("lim", 16);
        chk("lim_din0", wd_q[0], 32'h0000_FFFF);
        chk("lim_ovf", rxpy_overflow, 1);
        chk("lim_cnt", rxpybitcount, 16);

        // 32nd bit coincides with py_endp: single write, no extra flush
        clear_mon(); start_pl();
        for (int i = 0; i < 32; i++) begin
            b = 1'($urandom_range(0, 1)); pl_bits.push_back(b); bit_cyc(b, i == 31);
        end
        idle(4);
        check_writes("coinc", 32);
        chk("coinc_wr_lat", wc_q[0] - endp_cyc, 1);
        chk("coinc_done_lat", done_cyc - endp_cyc, 2);
        chk("coinc_done_n", done_n, 1);

        // Abort by dec_py_period falling after 10 bits; later strobes ignored
        clear_mon(); start_pl();
        for (int i = 0; i < 10; i++) bit_cyc(1'b1, 1'b0);
        dec_py_period = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) bit_cyc(1'b1, 1'b0);
        idle(4);
        chk("abort_nwr", wa_q.size(), 0);
        chk("abort_done_n", done_n, 0);
        chk("abort_cnt", rxpybitcount, 10);

        // Restart after 20 bits: stale partial word never written
        clear_mon(); start_pl();
        for (int i = 0; i < 20; i++) bit_cyc(1'b0, 1'b0);
        start_pl();
        for (int i = 0; i < 32; i++) begin
            pl_bits.push_back(1'b1); bit_cyc(1'b1, 1'b0);
        end
        end_pl();
        check_writes("restart", 32);
        chk("restart_din0", wd_q[0], 32'hFFFF_FFFF);
        chk("restart_cnt", rxpybitcount, 32);

        // Asynchronous reset mid-payload
        clear_mon(); start_pl();
        for (int i = 0; i < 10; i++) bit_cyc(1'b1, 1'b0);
        #2 rstz = 1'b0;
        #1;
        chk("arst_cnt", rxpybitcount, 0);
        chk("arst_we", rxlnctrl_we, 0);
        #3 rstz = 1'b1;
        idle(3);
        chk("arst_nwr", wa_q.size(), 0);
        chk("arst_done_n", done_n, 0);

        // Random payloads against the packing model
        for (int p = 0; p < 12; p++) begin
            clear_mon();
            nb = $urandom_range(0, 140);
            uselim = 1'($urandom_range(0, 1));
            lb = $urandom_range(0, 20);
            lim = uselim ? lb * 8 : 8192;
            together = (nb > 0) && ($urandom_range(0, 1) == 1);
            start_pl();
            if (uselim) begin
                pylen_valid_p = 1'b1; dec_pylenByte = 10'(lb);
                @(posedge clk_6M); #1;
                pylen_valid_p = 1'b0;
            end
            for (int i = 0; i < nb; i++) begin
                b = 1'($urandom_range(0, 1));
                pl_bits.push_back(b);
                last = together && (i == nb - 1);
                bit_cyc(b, last);
                if (!last) idle($urandom_range(0, 2));
            end
            if (together) idle(4);
            else end_pl();
            stored = (nb < lim) ? nb : lim;
            check_writes("rnd", stored);
            chk("rnd_cnt", rxpybitcount, stored);
            chk("rnd_ovf", rxpy_overflow, (nb > lim) ? 1 : 0);
            chk("rnd_done_n", done_n, 1);
            chk("rnd_done_lat", done_cyc - endp_cyc, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
